// File: rtl/rgb_to_ycbcr_block.sv
// Converts one captured 8x8 RGB block to JFIF Y/Cb/Cr, one pixel per cycle,
// through a two-stage multiply / sum-round-clamp pipeline.
module rgb_to_ycbcr_block (
  input  logic         Clock,
  input  logic         reset,
  input  logic         Enable,
  input  logic [511:0] R,
  input  logic [511:0] G,
  input  logic [511:0] B,
  output logic [511:0] Y,
  output logic [511:0] Cb,
  output logic [511:0] Cr,
  output logic         enable0,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e       state_q;
  logic [5:0]   idx_q;
  logic [511:0] r_q, g_q, b_q;
  logic [511:0] y_q, cb_q, cr_q;
  logic         enable0_q, busy_q;

  logic         s1_vld_q;
  logic [5:0]   s1_idx_q;
  logic [15:0]  p_yr_q, p_yg_q, p_yb_q;
  logic [15:0]  p_cbr_q, p_cbg_q, p_cbb_q;
  logic [15:0]  p_crr_q, p_crg_q, p_crb_q;

  logic [7:0]   r_pix_s, g_pix_s, b_pix_s;
  logic signed [17:0] y_acc_s, cb_acc_s, cr_acc_s;
  logic [7:0]   y_byte_d, cb_byte_d, cr_byte_d;

  // Pixel idx sits at bits [511-8*idx -: 8]; its LSB is 8*(63-idx) = {~idx, 3'b000}.
  function automatic logic [7:0] pick_byte(input logic [511:0] bus, input logic [5:0] idx);
    logic [511:0] sh;
    sh = bus >> {~idx, 3'b000};
    return sh[7:0];
  endfunction

  function automatic logic signed [17:0] to_s18(input logic [15:0] p);
    return $signed({2'b00, p});
  endfunction

  function automatic logic [7:0] round_clamp(input logic signed [17:0] acc);
    logic signed [17:0] sh;
    sh = acc >>> 4'd8;
    if (sh < 18'sd0) begin
      return 8'd0;
    end else if (sh > 18'sd255) begin
      return 8'd255;
    end else begin
      return sh[7:0];
    end
  endfunction

  // Select the current pixel's samples from the captured block.
  always_comb begin
    r_pix_s = pick_byte(r_q, idx_q);
    g_pix_s = pick_byte(g_q, idx_q);
    b_pix_s = pick_byte(b_q, idx_q);
  end

  // Stage-2 accumulation with the rounding constant and chroma offset folded in.
  always_comb begin
    y_acc_s  = to_s18(p_yr_q) + to_s18(p_yg_q) + to_s18(p_yb_q) + 18'sd128;
    cb_acc_s = 18'sd32896 - to_s18(p_cbr_q) - to_s18(p_cbg_q) + to_s18(p_cbb_q);
    cr_acc_s = 18'sd32896 + to_s18(p_crr_q) - to_s18(p_crg_q) - to_s18(p_crb_q);
    y_byte_d  = round_clamp(y_acc_s);
    cb_byte_d = round_clamp(cb_acc_s);
    cr_byte_d = round_clamp(cr_acc_s);
  end

  // Control FSM: capture, pixel issue, drain and completion handshake.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= 6'd0;
      r_q       <= 512'd0;
      g_q       <= 512'd0;
      b_q       <= 512'd0;
      enable0_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Enable) begin
            r_q     <= R;
            g_q     <= G;
            b_q     <= B;
            idx_q   <= 6'd0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          idx_q <= idx_q + 6'd1;
          if (idx_q == 6'd63) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          state_q   <= DONE;
          enable0_q <= 1'b1;
          busy_q    <= 1'b0;
        end
        DONE: begin
          if (!Enable) begin
            state_q   <= IDLE;
            enable0_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          enable0_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: the nine coefficient products for the pixel issued this cycle.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      s1_vld_q <= 1'b0;
      s1_idx_q <= 6'd0;
      p_yr_q   <= 16'd0;
      p_yg_q   <= 16'd0;
      p_yb_q   <= 16'd0;
      p_cbr_q  <= 16'd0;
      p_cbg_q  <= 16'd0;
      p_cbb_q  <= 16'd0;
      p_crr_q  <= 16'd0;
      p_crg_q  <= 16'd0;
      p_crb_q  <= 16'd0;
    end else begin
      s1_vld_q <= (state_q == CONV);
      if (state_q == CONV) begin
        s1_idx_q <= idx_q;
        p_yr_q   <= {8'd0, r_pix_s} * 16'd77;
        p_yg_q   <= {8'd0, g_pix_s} * 16'd150;
        p_yb_q   <= {8'd0, b_pix_s} * 16'd29;
        p_cbr_q  <= {8'd0, r_pix_s} * 16'd43;
        p_cbg_q  <= {8'd0, g_pix_s} * 16'd85;
        p_cbb_q  <= {8'd0, b_pix_s} * 16'd128;
        p_crr_q  <= {8'd0, r_pix_s} * 16'd128;
        p_crg_q  <= {8'd0, g_pix_s} * 16'd107;
        p_crb_q  <= {8'd0, b_pix_s} * 16'd21;
      end
    end
  end

  // Stage 2: write the finished pixel into its byte lane of the output buses.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      y_q  <= 512'd0;
      cb_q <= 512'd0;
      cr_q <= 512'd0;
    end else begin
      if (s1_vld_q) begin
        y_q[{~s1_idx_q, 3'b111} -: 8]  <= y_byte_d;
        cb_q[{~s1_idx_q, 3'b111} -: 8] <= cb_byte_d;
        cr_q[{~s1_idx_q, 3'b111} -: 8] <= cr_byte_d;
      end
    end
  end

  assign Y       = y_q;
  assign Cb      = cb_q;
  assign Cr      = cr_q;
  assign enable0 = enable0_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_rgb_to_ycbcr_block.sv
// Table-driven bench with an expected-result queue for rgb_to_ycbcr_block.
module tb_rgb_to_ycbcr_block;

  logic         Clock = 1'b0;
  logic         reset;
  logic         Enable;
  logic [511:0] R, G, B;
  logic [511:0] Y, Cb, Cr;
  logic         enable0, busy;

  rgb_to_ycbcr_block dut (
    .Clock(Clock), .reset(reset), .Enable(Enable),
    .R(R), .G(G), .B(B),
    .Y(Y), .Cb(Cb), .Cr(Cr),
    .enable0(enable0), .busy(busy)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [511:0] r, g, b;
    logic [511:0] y, cb, cr;
    int           mode;   // 0: drop Enable mid-block, 1: hold Enable past completion
  } vec_t;

  typedef struct {
    logic [511:0] y, cb, cr;
  } exp_t;

  vec_t vecs[7];
  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic int px(input logic [511:0] bus, input int k);
    logic [511:0] s;
    s = bus >> (8 * (63 - k));
    return {24'd0, s[7:0]};
  endfunction

  function automatic int clampv(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic exp_t model(input logic [511:0] r, input logic [511:0] g, input logic [511:0] b);
    exp_t e;
    int rv, gv, bv, yv, cbv, crv;
    for (int k = 0; k < 64; k++) begin
      rv  = px(r, k);
      gv  = px(g, k);
      bv  = px(b, k);
      yv  = clampv((77 * rv + 150 * gv + 29 * bv + 128) >>> 8);
      cbv = clampv((-43 * rv - 85 * gv + 128 * bv + 32768 + 128) >>> 8);
      crv = clampv((128 * rv - 107 * gv - 21 * bv + 32768 + 128) >>> 8);
      e.y[511 - 8 * k -: 8]  = yv[7:0];
      e.cb[511 - 8 * k -: 8] = cbv[7:0];
      e.cr[511 - 8 * k -: 8] = crv[7:0];
    end
    return e;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[32 * k +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_bus(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic check_val(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic run_block(input logic [511:0] r, input logic [511:0] g, input logic [511:0] b,
                           input logic [511:0] ey, input logic [511:0] ecb, input logic [511:0] ecr,
                           input int mode, input string nm);
    int   n;
    int   busy_n;
    exp_t got;
    R = r; G = g; B = b; Enable = 1'b1;
    sb_q.push_back('{ey, ecb, ecr});
    @(posedge Clock); #1;
    R = ~r; G = ~g; B = ~b;
    n = 0;
    busy_n = busy ? 1 : 0;
    while (!enable0 && n < 200) begin
      if (mode == 0 && n == 5) Enable = 1'b0;
      @(posedge Clock); #1;
      n++;
      if (busy) busy_n++;
    end
    check_val({nm, " latency"}, n, 65);
    check_val({nm, " busy_cycles"}, busy_n, 65);
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      check_bus({nm, " Y"}, Y, got.y);
      check_bus({nm, " Cb"}, Cb, got.cb);
      check_bus({nm, " Cr"}, Cr, got.cr);
    end
    if (mode == 1) begin
      repeat (3) @(posedge Clock);
      #1;
      check_val({nm, " enable0_hold"}, int'(enable0), 1);
      Enable = 1'b0;
      @(posedge Clock); #1;
      check_val({nm, " enable0_clear"}, int'(enable0), 0);
    end else begin
      @(posedge Clock); #1;
      check_val({nm, " enable0_pulse"}, int'(enable0), 0);
      check_bus({nm, " Y_idle_hold"}, Y, ey);
    end
  endtask

  initial begin
    exp_t e;
    logic [511:0] rr, gg, bb;

    vecs[0] = '{{64{8'hFF}}, {64{8'hFF}}, {64{8'hFF}}, {64{8'hFF}}, {64{8'h80}}, {64{8'h80}}, 1};
    vecs[1] = '{512'd0, 512'd0, 512'd0, 512'd0, {64{8'h80}}, {64{8'h80}}, 0};
    vecs[2] = '{{64{8'hFF}}, 512'd0, 512'd0, {64{8'd77}}, {64{8'd85}}, {64{8'd255}}, 0};
    vecs[3] = '{512'd0, 512'd0, {64{8'hFF}}, {64{8'd29}}, {64{8'd255}}, {64{8'd107}}, 1};
    vecs[4] = '{{8'hFF, 504'd0}, 512'd0, {504'd0, 8'hFF},
                {8'd77, 496'd0, 8'd29},
                {8'd85, {62{8'h80}}, 8'd255},
                {8'd255, {62{8'h80}}, 8'd107}, 1};
    for (int i = 5; i < 7; i++) begin
      vecs[i].r = rand512();
      vecs[i].g = rand512();
      vecs[i].b = rand512();
      e = model(vecs[i].r, vecs[i].g, vecs[i].b);
      vecs[i].y = e.y; vecs[i].cb = e.cb; vecs[i].cr = e.cr;
      vecs[i].mode = i - 5;
    end

    reset = 1'b0; Enable = 1'b0; R = 512'd0; G = 512'd0; B = 512'd0;
    #12;
    check_bus("reset Y", Y, 512'd0);
    check_bus("reset Cb", Cb, 512'd0);
    check_bus("reset Cr", Cr, 512'd0);
    check_val("reset enable0", int'(enable0), 0);
    check_val("reset busy", int'(busy), 0);
    @(posedge Clock); #1;
    reset = 1'b1;
    @(posedge Clock); #1;

    for (int i = 0; i < 7; i++) begin
      run_block(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].y, vecs[i].cb, vecs[i].cr,
                vecs[i].mode, $sformatf("vec%0d", i));
      if (i == 4) begin
        check_val("order Y[511:504]", int'(Y[511:504]), 77);
        check_val("order Y[7:0]", int'(Y[7:0]), 29);
        check_val("order Cb[7:0]", int'(Cb[7:0]), 255);
        check_bus("order Y middle", {8'd0, Y[503:8], 8'd0}, 512'd0);
      end
    end

    // Abort a block with reset around pixel 30.
    rr = rand512(); gg = rand512(); bb = rand512();
    R = rr; G = gg; B = bb; Enable = 1'b1;
    @(posedge Clock);
    repeat (31) @(posedge Clock);
    #1;
    reset = 1'b0;
    #1;
    check_bus("async_rst Y", Y, 512'd0);
    check_bus("async_rst Cb", Cb, 512'd0);
    check_bus("async_rst Cr", Cr, 512'd0);
    check_val("async_rst enable0", int'(enable0), 0);
    check_val("async_rst busy", int'(busy), 0);
    Enable = 1'b0;
    @(posedge Clock); #1;
    reset = 1'b1;
    @(posedge Clock); #1;
    check_val("post_rst enable0", int'(enable0), 0);
    e = model(rr, gg, bb);
    run_block(rr, gg, bb, e.y, e.cb, e.cr, 1, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
